// File: rtl/pspin_seq_pkg.sv
// Shared state encoding for the PsPIN cluster lifecycle sequencer.
// The register block imports this package to decode the state_o field.
package pspin_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_RST_HOLD = 3'd1;
    localparam logic [STATE_W-1:0] ST_RST_REL  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ENABLE   = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN      = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = ST_IDLE,
        RST_HOLD = ST_RST_HOLD,
        RST_REL  = ST_RST_REL,
        ENABLE   = ST_ENABLE,
        RUN      = ST_RUN,
        DRAIN    = ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/pspin_seq_timer.sv
// Loadable down-counter shared by the reset-hold, stagger and drain phases.
// A load takes priority over counting; the count saturates at zero.
module pspin_seq_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pspin_cluster_seq.sv
// Lifecycle sequencer for the PsPIN clusters: reset hold/release, staggered
// fetch enables, run with end-of-computation detection and a bounded drain.
module pspin_cluster_seq
    import pspin_seq_pkg::*;
#(
    parameter int NUM_CLUSTERS    = 2,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_start_i,
    input  logic                    cmd_stop_i,
    input  logic [NUM_CLUSTERS-1:0] cl_mask_i,
    input  logic [NUM_CLUSTERS-1:0] cl_eoc_i,
    input  logic [NUM_CLUSTERS-1:0] cl_busy_i,
    output logic                    aux_rst_o,
    output logic [NUM_CLUSTERS-1:0] cl_fetch_en_o,
    output logic [STATE_W-1:0]      state_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic                    cmd_err_o
);

    localparam int MAX_HS    = (RST_HOLD_CYCLES > STAGGER_CYCLES) ? RST_HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CYC   = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
    localparam int CNT_WIDTH = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD    = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAGGER_LOAD = CNT_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD   = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

    seq_state_e                state_q, state_d;
    logic [NUM_CLUSTERS-1:0]   mask_q, mask_d;
    logic [NUM_CLUSTERS-1:0]   fetch_en_q, fetch_en_d;
    logic                      aux_rst_q, aux_rst_d;
    logic                      done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic                      cmd_err_q, cmd_err_d;

    logic                      tmr_load, tmr_en, tmr_zero;
    logic [CNT_WIDTH-1:0]      tmr_value;
    logic [NUM_CLUSTERS-1:0]   remaining;
    logic                      start_only;

    // One-hot of the lowest set bit: picks the next cluster to enable.
    function automatic logic [NUM_CLUSTERS-1:0] lowest_bit(input logic [NUM_CLUSTERS-1:0] v);
        logic [NUM_CLUSTERS-1:0] r;
        logic                    found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    pspin_seq_timer #(.WIDTH(CNT_WIDTH)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .en_i    (tmr_en),
        .zero_o  (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            fetch_en_q <= '0;
            aux_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            fetch_en_q <= fetch_en_d;
            aux_rst_q  <= aux_rst_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // A stop always beats a simultaneous start.
    assign start_only = cmd_start_i && !cmd_stop_i;
    assign remaining  = mask_q & ~fetch_en_q;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        cmd_err_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_only) begin
                    if (cl_mask_i != '0) begin
                        mask_d    = cl_mask_i;
                        timeout_d = 1'b0;
                        state_d   = RST_HOLD;
                        tmr_load  = 1'b1;
                        tmr_value = HOLD_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            RST_HOLD, RST_REL, ENABLE: begin
                cmd_err_d = start_only;
                if (cmd_stop_i) begin
                    state_d   = DRAIN;
                    tmr_load  = 1'b1;
                    tmr_value = DRAIN_LOAD;
                end else if (state_q == ENABLE && remaining == '0) begin
                    state_d = RUN;
                end else if (tmr_zero) begin
                    if (state_q == RST_HOLD)     state_d = RST_REL;
                    else if (state_q == RST_REL) state_d = ENABLE;
                    tmr_load  = 1'b1;
                    tmr_value = STAGGER_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RUN: begin
                cmd_err_d = start_only;
                if (cmd_stop_i || done_q) begin
                    state_d   = DRAIN;
                    tmr_load  = 1'b1;
                    tmr_value = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                cmd_err_d = start_only;
                if ((cl_busy_i & mask_q) == '0) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they change with it.
    always_comb begin
        fetch_en_d = '0;
        case (state_d)
            ENABLE: begin
                if (state_q != ENABLE)
                    fetch_en_d = lowest_bit(mask_q);
                else if (tmr_zero)
                    fetch_en_d = fetch_en_q | lowest_bit(remaining);
                else
                    fetch_en_d = fetch_en_q;
            end
            RUN:     fetch_en_d = fetch_en_q;
            default: fetch_en_d = '0;
        endcase
        aux_rst_d = (state_d == IDLE) || (state_d == RST_HOLD);
        done_d    = (state_d == RUN) && (&(cl_eoc_i | ~mask_q));
    end

    assign aux_rst_o     = aux_rst_q;
    assign cl_fetch_en_o = fetch_en_q;
    assign state_o       = state_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cmd_err_o     = cmd_err_q;

endmodule

// File: tb/tb_pspin_cluster_seq.sv
// Directed self-checking bench for pspin_cluster_seq with default parameters.
// Cycle T is the cycle in which an accepted start is driven; checks sample 1 ns after each rising edge.
module tb_pspin_cluster_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_start_i = 1'b0;
    logic       cmd_stop_i = 1'b0;
    logic [1:0] cl_mask_i = 2'b00;
    logic [1:0] cl_eoc_i = 2'b00;
    logic [1:0] cl_busy_i = 2'b00;
    logic       aux_rst_o;
    logic [1:0] cl_fetch_en_o;
    logic [2:0] state_o;
    logic       done_o;
    logic       timeout_o;
    logic       cmd_err_o;

    int checks = 0;
    int errors = 0;

    pspin_cluster_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start_i   (cmd_start_i),
        .cmd_stop_i    (cmd_stop_i),
        .cl_mask_i     (cl_mask_i),
        .cl_eoc_i      (cl_eoc_i),
        .cl_busy_i     (cl_busy_i),
        .aux_rst_o     (aux_rst_o),
        .cl_fetch_en_o (cl_fetch_en_o),
        .state_o       (state_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .cmd_err_o     (cmd_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        checks++; if (aux_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_aux: got %b expected 1", aux_rst_o); end
        checks++; if (cl_fetch_en_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_fetch: got %b expected 00", cl_fetch_en_o); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if ({done_o, timeout_o, cmd_err_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {done_o, timeout_o, cmd_err_o}); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_idle: got %0d expected 0", state_o); end
    endtask

    // Full start sequence with mask 11; ends in cycle T+26 with the DUT in RUN.
    task automatic test_start_seq();
        cl_mask_i = 2'b11; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        checks++; if (state_o !== 3'd1) begin errors++; $display("[TB] FAIL seq_hold_state: got %0d expected 1", state_o); end
        ticks(15);
        checks++; if (aux_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL seq_aux_T16: got %b expected 1", aux_rst_o); end
        tick();
        checks++; if (aux_rst_o !== 1'b0) begin errors++; $display("[TB] FAIL seq_aux_T17: got %b expected 0", aux_rst_o); end
        checks++; if (state_o !== 3'd2) begin errors++; $display("[TB] FAIL seq_rel_state: got %0d expected 2", state_o); end
        ticks(3);
        checks++; if (cl_fetch_en_o !== 2'b00) begin errors++; $display("[TB] FAIL seq_fetch_T20: got %b expected 00", cl_fetch_en_o); end
        tick();
        checks++; if (cl_fetch_en_o !== 2'b01) begin errors++; $display("[TB] FAIL seq_fetch_T21: got %b expected 01", cl_fetch_en_o); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL seq_enable_state: got %0d expected 3", state_o); end
        ticks(3);
        checks++; if (cl_fetch_en_o !== 2'b01) begin errors++; $display("[TB] FAIL seq_fetch_T24: got %b expected 01", cl_fetch_en_o); end
        tick();
        checks++; if (cl_fetch_en_o !== 2'b11) begin errors++; $display("[TB] FAIL seq_fetch_T25: got %b expected 11", cl_fetch_en_o); end
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL seq_state_T25: got %0d expected 3", state_o); end
        tick();
        checks++; if (state_o !== 3'd4) begin errors++; $display("[TB] FAIL seq_run_T26: got %0d expected 4", state_o); end
        checks++; if (cl_fetch_en_o !== 2'b11 || done_o !== 1'b0) begin errors++; $display("[TB] FAIL seq_run_outputs: got fetch=%b done=%b expected fetch=11 done=0", cl_fetch_en_o, done_o); end
    endtask

    task automatic run_to_run(input logic [1:0] mask);
        int n;
        cl_mask_i = mask; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        n = 0;
        while (state_o !== 3'd4 && n < 60) begin tick(); n++; end
        checks++; if (state_o !== 3'd4) begin errors++; $display("[TB] FAIL reach_run: got state %0d expected 4 within 60 cycles", state_o); end
    endtask

    task automatic test_done();
        cl_eoc_i = 2'b11; cl_busy_i = 2'b00;
        tick();
        checks++; if (done_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("[TB] FAIL done_detect: got done=%b state=%0d expected done=1 state=4", done_o, state_o); end
        tick();
        checks++; if (state_o !== 3'd5 || cl_fetch_en_o !== 2'b00 || aux_rst_o !== 1'b0) begin errors++; $display("[TB] FAIL done_drain: got state=%0d fetch=%b aux=%b expected 5/00/0", state_o, cl_fetch_en_o, aux_rst_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL done_clear: got %b expected 0", done_o); end
        tick();
        checks++; if (state_o !== 3'd0 || aux_rst_o !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL done_idle: got state=%0d aux=%b timeout=%b expected 0/1/0", state_o, aux_rst_o, timeout_o); end
        cl_eoc_i = 2'b00;
        tick();
    endtask

    task automatic test_drain_timeout();
        int n;
        run_to_run(2'b11);
        cl_busy_i = 2'b01; cmd_stop_i = 1'b1;
        tick();
        cmd_stop_i = 1'b0;
        checks++; if (state_o !== 3'd5 || cl_fetch_en_o !== 2'b00) begin errors++; $display("[TB] FAIL stop_drain: got state=%0d fetch=%b expected 5/00", state_o, cl_fetch_en_o); end
        n = 0;
        while (state_o === 3'd5 && n < 1100) begin n++; tick(); end
        checks++; if (n !== 1024) begin errors++; $display("[TB] FAIL drain_cycles: got %0d expected 1024", n); end
        checks++; if (state_o !== 3'd0 || timeout_o !== 1'b1 || aux_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL drain_timeout: got state=%0d timeout=%b aux=%b expected 0/1/1", state_o, timeout_o, aux_rst_o); end
        cl_busy_i = 2'b00;
        tick();
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_o); end
        cl_mask_i = 2'b01; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        checks++; if (timeout_o !== 1'b0 || state_o !== 3'd1) begin errors++; $display("[TB] FAIL timeout_clear: got timeout=%b state=%0d expected 0/1", timeout_o, state_o); end
        cmd_stop_i = 1'b1;
        tick();
        cmd_stop_i = 1'b0;
        checks++; if (state_o !== 3'd5) begin errors++; $display("[TB] FAIL hold_stop: got %0d expected 5", state_o); end
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL hold_stop_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_cmd_err();
        cmd_stop_i = 1'b1;
        tick();
        cmd_stop_i = 1'b0;
        checks++; if (state_o !== 3'd0 || cmd_err_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_stop: got state=%0d err=%b expected 0/0", state_o, cmd_err_o); end
        cl_mask_i = 2'b00; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0;
        checks++; if (cmd_err_o !== 1'b1 || state_o !== 3'd0) begin errors++; $display("[TB] FAIL zero_mask_err: got err=%b state=%0d expected 1/0", cmd_err_o, state_o); end
        tick();
        checks++; if (cmd_err_o !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse_width: got %b expected 0", cmd_err_o); end
        cl_mask_i = 2'b11; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        ticks(3);
        cl_mask_i = 2'b01; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        checks++; if (cmd_err_o !== 1'b1 || state_o !== 3'd1) begin errors++; $display("[TB] FAIL busy_start_err: got err=%b state=%0d expected 1/1", cmd_err_o, state_o); end
        tick();
        checks++; if (cmd_err_o !== 1'b0 || state_o !== 3'd1 || aux_rst_o !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_after: got err=%b state=%0d aux=%b expected 0/1/1", cmd_err_o, state_o, aux_rst_o); end
        cmd_stop_i = 1'b1;
        tick();
        cmd_stop_i = 1'b0;
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL err_abort_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_single_cluster();
        cl_mask_i = 2'b10; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        ticks(20);
        checks++; if (cl_fetch_en_o !== 2'b10 || state_o !== 3'd3) begin errors++; $display("[TB] FAIL single_enable: got fetch=%b state=%0d expected 10/3", cl_fetch_en_o, state_o); end
        tick();
        checks++; if (state_o !== 3'd4 || cl_fetch_en_o !== 2'b10) begin errors++; $display("[TB] FAIL single_run: got state=%0d fetch=%b expected 4/10", state_o, cl_fetch_en_o); end
        cmd_stop_i = 1'b1;
        tick();
        cmd_stop_i = 1'b0;
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL single_idle: got %0d expected 0", state_o); end
        cl_mask_i = 2'b11; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        ticks(21);
        checks++; if (state_o !== 3'd3 || cl_fetch_en_o !== 2'b01) begin errors++; $display("[TB] FAIL both_enable_T22: got state=%0d fetch=%b expected 3/01", state_o, cl_fetch_en_o); end
        cmd_start_i = 1'b1; cmd_stop_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cmd_stop_i = 1'b0;
        checks++; if (state_o !== 3'd5 || cl_fetch_en_o !== 2'b00 || cmd_err_o !== 1'b0) begin errors++; $display("[TB] FAIL start_stop_enable: got state=%0d fetch=%b err=%b expected 5/00/0", state_o, cl_fetch_en_o, cmd_err_o); end
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL start_stop_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_async_reset();
        cl_mask_i = 2'b11; cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0; cl_mask_i = 2'b00;
        ticks(22);
        checks++; if (state_o !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_enable: got %0d expected 3", state_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (aux_rst_o !== 1'b1 || cl_fetch_en_o !== 2'b00 || state_o !== 3'd0) begin errors++; $display("[TB] FAIL async_reset: got aux=%b fetch=%b state=%0d expected 1/00/0", aux_rst_o, cl_fetch_en_o, state_o); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_start_seq();
    endtask

    initial begin
        test_reset();
        test_start_seq();
        test_done();
        test_drain_timeout();
        test_cmd_err();
        test_single_cluster();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
